// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through frame FIFO. Each word carries {ferr, perr, data}.
// Frame format, baud divisor and FIFO depth are parameters.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 785,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              rx,
    input  logic                              m_ready,
    output logic                              m_valid,
    output logic [DATA_BITS-1:0]              m_data,
    output logic                              m_perr,
    output logic                              m_ferr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    input  logic                              err_clr,
    output logic                              interrupt
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH+1);
    localparam int WW = DATA_BITS + 2;

    localparam logic [CW-1:0] C_HALF  = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] C_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    C_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    C_SLAST = 4'(STOP_BITS - 1);
    localparam logic [NW-1:0] C_DEPTH = NW'(FIFO_DEPTH);
    localparam logic          C_ODD   = (PARITY == 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PAR     = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;

    logic                 w_tick;
    logic                 w_push;
    logic                 w_push_ferr;
    logic [WW-1:0]        w_push_word;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick      = (r_clk_cnt == C_FULL);
    assign w_push      = (r_state == S_STOP) && w_tick && (r_bit_cnt == C_SLAST);
    assign w_push_ferr = r_ferr | ~r_rx_s;
    assign w_push_word = {w_push_ferr, r_perr, r_shift};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state   <= S_START;
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                    end
                end
                S_START: begin
                    // Re-check the start bit at its midpoint to reject glitches.
                    if (r_clk_cnt == C_HALF) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == C_DLAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_PAR: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_perr    <= ((^r_shift) ^ r_rx_s) != C_ODD;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        if (!r_rx_s) r_ferr <= 1'b1;
                        if (r_bit_cnt == C_SLAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= w_push_ferr ? S_RECOVER : S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_RECOVER: begin
                    // A held break must not look like a stream of new start bits.
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [WW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [NW-1:0] r_count;
    logic          r_overrun;
    logic          r_interrupt;

    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic [WW-1:0] w_head;

    assign m_valid = (r_count != '0);
    assign w_full  = (r_count == C_DEPTH);
    assign w_pop   = m_valid && m_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_push_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overrun   <= 1'b0;
            r_interrupt <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_wr && !w_pop)      r_count <= r_count + NW'(1);
            else if (!w_wr && w_pop) r_count <= r_count - NW'(1);
            // Setting takes priority over a simultaneous clear.
            if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
            else if (err_clr)               r_overrun <= 1'b0;
            r_interrupt <= m_valid | r_overrun;
        end
    end

    // Head fields read as zero while empty so nothing stale is exposed.
    assign m_data     = m_valid ? w_head[DATA_BITS-1:0] : '0;
    assign m_perr     = m_valid ? w_head[DATA_BITS]     : 1'b0;
    assign m_ferr     = m_valid ? w_head[DATA_BITS+1]   : 1'b0;
    assign fifo_count = r_count;
    assign overrun    = r_overrun;
    assign interrupt  = r_interrupt;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three instances (8E1, 8O1, 7N2) driven bit-by-bit,
// received words compared against a per-instance queue of expected {ferr, perr, data}.
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] rx = 3'b111;
    logic [2:0] m_ready = 3'b000;
    logic [2:0] err_clr = 3'b000;
    logic [2:0] m_valid, m_perr, m_ferr, overrun, interrupt;
    logic [7:0] m_data0, m_data1;
    logic [6:0] m_data2;
    logic [4:0] cnt0, cnt1, cnt2;

    int checks = 0;
    int failures = 0;
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
        .clk(clk), .reset(reset), .rx(rx[0]), .m_ready(m_ready[0]), .m_valid(m_valid[0]),
        .m_data(m_data0), .m_perr(m_perr[0]), .m_ferr(m_ferr[0]), .fifo_count(cnt0),
        .overrun(overrun[0]), .err_clr(err_clr[0]), .interrupt(interrupt[0]));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut1 (
        .clk(clk), .reset(reset), .rx(rx[1]), .m_ready(m_ready[1]), .m_valid(m_valid[1]),
        .m_data(m_data1), .m_perr(m_perr[1]), .m_ferr(m_ferr[1]), .fifo_count(cnt1),
        .overrun(overrun[1]), .err_clr(err_clr[1]), .interrupt(interrupt[1]));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) dut2 (
        .clk(clk), .reset(reset), .rx(rx[2]), .m_ready(m_ready[2]), .m_valid(m_valid[2]),
        .m_data(m_data2), .m_perr(m_perr[2]), .m_ferr(m_ferr[2]), .fifo_count(cnt2),
        .overrun(overrun[2]), .err_clr(err_clr[2]), .interrupt(interrupt[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] get_word(input int inst);
        case (inst)
            0:       return {m_ferr[0], m_perr[0], 1'b0, m_data0};
            1:       return {m_ferr[1], m_perr[1], 1'b0, m_data1};
            default: return {m_ferr[2], m_perr[2], 2'b00, m_data2};
        endcase
    endfunction

    function automatic logic [4:0] get_count(input int inst);
        case (inst)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction

    // Reference parity check: data ones plus parity bit must be even (odd=0) or odd (odd=1).
    function automatic logic par_err(input logic [8:0] data, input logic pbit, input logic odd);
        int ones = 0;
        for (int i = 0; i < 9; i++) ones += int'(data[i]);
        ones += int'(pbit);
        return ((ones % 2) == 1) != odd;
    endfunction

    task automatic expect_word(input int inst, input logic ferr, input logic perr, input logic [8:0] data);
        logic [10:0] w;
        w = {ferr, perr, data};
        case (inst)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    task automatic drive_bit(input int inst, input logic v, input int clocks);
        rx[inst] = v;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic uart_send(input int inst, input logic [8:0] data, input int dbits, input bit has_par,
                             input logic pbit, input int nstop, input logic last_stop, input int extra_low);
        drive_bit(inst, 1'b0, CPB);
        for (int i = 0; i < dbits; i++) drive_bit(inst, data[i], CPB);
        if (has_par) drive_bit(inst, pbit, CPB);
        for (int s = 0; s < nstop; s++) drive_bit(inst, (s == nstop - 1) ? last_stop : 1'b1, CPB);
        if (extra_low > 0) drive_bit(inst, 1'b0, extra_low);
        rx[inst] = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_check(input int inst, input string tag);
        int n = 0;
        logic [10:0] exp;
        while (!m_valid[inst] && n < 400) begin
            @(negedge clk);
            n++;
        end
        case (inst)
            0:       exp = (q0.size() > 0) ? q0.pop_front() : 11'h7FF;
            1:       exp = (q1.size() > 0) ? q1.pop_front() : 11'h7FF;
            default: exp = (q2.size() > 0) ? q2.pop_front() : 11'h7FF;
        endcase
        check({tag, "_valid"}, 32'(m_valid[inst]), 32'd1);
        check(tag, 32'(get_word(inst)), 32'(exp));
        $display("pop dut%0d %s word=0x%0h expected=0x%0h count=%0d", inst, tag, get_word(inst), exp, get_count(inst));
        m_ready[inst] = 1'b1;
        @(negedge clk);
        m_ready[inst] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_irq", 32'(interrupt), 32'd0);
        check("rst_data", 32'(m_data0), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 0x75 8E1 with correct parity
        expect_word(0, 1'b0, par_err(9'h75, 1'b1, 1'b0), 9'h75);
        uart_send(0, 9'h75, 8, 1, 1'b1, 1, 1'b1, 0);
        check("t1_count", 32'(cnt0), 32'd1);
        check("t1_irq", 32'(interrupt[0]), 32'd1);
        pop_check(0, "t1_word");
        check("t1_count_after", 32'(cnt0), 32'd0);

        // Wrong parity bit for even; the same bit is correct for odd parity
        expect_word(0, 1'b0, par_err(9'h75, 1'b0, 1'b0), 9'h75);
        uart_send(0, 9'h75, 8, 1, 1'b0, 1, 1'b1, 0);
        pop_check(0, "t2_even_perr");
        expect_word(1, 1'b0, par_err(9'h75, 1'b0, 1'b1), 9'h75);
        uart_send(1, 9'h75, 8, 1, 1'b0, 1, 1'b1, 0);
        pop_check(1, "t2_odd_ok");
        expect_word(1, 1'b0, par_err(9'h75, 1'b1, 1'b1), 9'h75);
        uart_send(1, 9'h75, 8, 1, 1'b1, 1, 1'b1, 0);
        pop_check(1, "t2_odd_perr");

        // Stop bit low, line held low afterwards: exactly one word with ferr
        expect_word(0, 1'b1, par_err(9'hA5, 1'b0, 1'b0), 9'hA5);
        uart_send(0, 9'hA5, 8, 1, 1'b0, 1, 1'b0, 40);
        repeat (3 * CPB) @(negedge clk);
        check("t3_count", 32'(cnt0), 32'd1);
        pop_check(0, "t3_ferr");
        repeat (2) @(negedge clk);
        check("t3_no_second", 32'(cnt0), 32'd0);

        // Short low glitch is rejected; a following frame still arrives intact
        drive_bit(0, 1'b0, 6);
        rx[0] = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("t4_count", 32'(cnt0), 32'd0);
        check("t4_valid", 32'(m_valid[0]), 32'd0);
        expect_word(0, 1'b0, 1'b0, 9'h5A);
        uart_send(0, 9'h5A, 8, 1, 1'b0, 1, 1'b1, 0);
        pop_check(0, "t4_after_glitch");

        // 17 frames into a 16-deep FIFO: last one dropped, overrun sticky until err_clr
        for (int i = 0; i < 17; i++) begin
            logic [8:0] d;
            d = 9'(i);
            if (i < 16) expect_word(0, 1'b0, 1'b0, d);
            uart_send(0, d, 8, 1, ^d[7:0], 1, 1'b1, 0);
        end
        check("t5_count_full", 32'(cnt0), 32'd16);
        check("t5_overrun", 32'(overrun[0]), 32'd1);
        for (int i = 0; i < 16; i++) pop_check(0, $sformatf("t5_pop%0d", i));
        @(negedge clk);
        check("t5_count_empty", 32'(cnt0), 32'd0);
        check("t5_overrun_sticky", 32'(overrun[0]), 32'd1);
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        @(negedge clk);
        check("t5_overrun_clr", 32'(overrun[0]), 32'd0);
        check("t5_irq_clr", 32'(interrupt[0]), 32'd0);

        // Reset mid-frame flushes the FIFO and discards the partial frame
        uart_send(0, 9'h11, 8, 1, 1'b0, 1, 1'b1, 0);
        check("t6_pre_count", 32'(cnt0), 32'd1);
        drive_bit(0, 1'b0, CPB);
        drive_bit(0, 1'b0, CPB);
        drive_bit(0, 1'b0, CPB);
        drive_bit(0, 1'b1, CPB / 2);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rx[0] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("t6_flush_count", 32'(cnt0), 32'd0);
        check("t6_flush_valid", 32'(m_valid[0]), 32'd0);
        expect_word(0, 1'b0, 1'b0, 9'hC3);
        uart_send(0, 9'hC3, 8, 1, 1'b0, 1, 1'b1, 0);
        pop_check(0, "t6_c3");
        @(negedge clk);
        check("t6_count_after", 32'(cnt0), 32'd0);

        // 7 data bits, no parity, two stop bits; second stop low gives ferr
        expect_word(2, 1'b0, 1'b0, 9'h55);
        uart_send(2, 9'h55, 7, 0, 1'b0, 2, 1'b1, 0);
        pop_check(2, "t6_7n2");
        expect_word(2, 1'b1, 1'b0, 9'h2A);
        uart_send(2, 9'h2A, 7, 0, 1'b0, 2, 1'b0, 0);
        pop_check(2, "t6_7n2_ferr");
        @(negedge clk);
        check("t6_7n2_count", 32'(cnt2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
